// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: special encodings, fetch-buffer entry type and
// PC helpers used by the instruction-fetch stage.
package pipe_pkg;

  localparam logic [31:0] NOP_INS    = 32'hdc00_0000;
  localparam logic [5:0]  OP_HALT    = 6'b111111;
  localparam logic [1:0]  STOP_NONE  = 2'b00;
  localparam logic [1:0]  STOP_JUMP  = 2'b11;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HALT  = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + WORD_BYTES;
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hffff_fffc;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO of {pc, ins} fetch entries with flush; flush wins
// over push/pop, and push into a full FIFO is accepted when a pop frees a slot.
module if_fifo
  import pipe_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstd,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign empty = (count_r == CNT_W'(0));
  assign full  = (count_r == CNT_W'(DEPTH));
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // Qualify requests against occupancy
  always_comb begin
    pop_s  = pop && !empty && !flush;
    push_s = push && !flush && (!full || pop_s);
  end

  // Entry storage
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else if (flush) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, single-outstanding req/ack fetch,
// instruction buffering and {pc, ins} presentation to the F/D register.
module if_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic [1:0]  stop_d,
  input  logic [5:0]  op_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] ins_out,
  output logic        halted
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  if_state_t        state_r, state_s;
  logic [31:0]      fetch_pc_r, fetch_pc_s;
  logic [31:0]      addr_r;
  logic [31:0]      last_pc_r;
  logic             drop_r, drop_s;
  logic             halted_r;

  logic             halt_any_s;
  logic             ack_s;
  logic             can_issue_s;
  logic             push_s;
  logic             pop_s;
  logic             flush_s;
  logic [CNT_W:0]   occ_s;
  fetch_entry_t     push_data_s;
  fetch_entry_t     head_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic             fifo_empty_s;
  logic             fifo_full_s;

  if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rstd      (rstd),
    .flush     (flush_s),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  // Handshake qualification and FIFO control; halt dominates redirect, redirect dominates stall
  always_comb begin
    halt_any_s  = (op_d == OP_HALT) || halted_r;
    ack_s       = (state_r == WAIT) && imem_ack;
    occ_s       = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, (state_r == WAIT)};
    can_issue_s = (state_r == FETCH) && !halt_any_s && !redirect_valid && !fifo_full_s
                  && (occ_s < (CNT_W+1)'(FIFO_DEPTH));
    push_s      = ack_s && !drop_r && !redirect_valid && !halt_any_s;
    pop_s       = !fifo_empty_s && (stop_d == STOP_NONE) && !redirect_valid && !halt_any_s;
    flush_s     = halt_any_s || redirect_valid;
    push_data_s = '{pc: fetch_pc_r, ins: imem_rdata};
  end

  // Next-state, fetch PC and drop-flag logic
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    drop_s     = drop_r;
    case (state_r)
      FETCH: begin
        if (halt_any_s)       state_s = HALT;
        else if (can_issue_s) state_s = WAIT;
        else                  state_s = FETCH;
      end
      WAIT: begin
        if (ack_s) state_s = halt_any_s ? HALT : FETCH;
        else       state_s = WAIT;
      end
      HALT:    state_s = HALT;
      default: state_s = FETCH;
    endcase
    if (halt_any_s) begin
      fetch_pc_s = fetch_pc_r;
      drop_s     = drop_r;
    end else if (redirect_valid) begin
      fetch_pc_s = align_pc(redirect_pc);
      // an in-flight request not completing now belongs to the old path
      drop_s     = (state_r == WAIT) && !imem_ack;
    end else if (push_s) begin
      fetch_pc_s = next_pc(fetch_pc_r);
      drop_s     = drop_r;
    end else if (ack_s) begin
      fetch_pc_s = fetch_pc_r;
      drop_s     = 1'b0;
    end else begin
      fetch_pc_s = fetch_pc_r;
      drop_s     = drop_r;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_r    <= FETCH;
      fetch_pc_r <= RESET_PC;
      addr_r     <= RESET_PC;
      last_pc_r  <= RESET_PC;
      drop_r     <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      drop_r     <= drop_s;
      halted_r   <= halt_any_s;
      if (can_issue_s)   addr_r    <= fetch_pc_r;
      if (!fifo_empty_s) last_pc_r <= head_s.pc;
    end
  end

  assign imem_req  = (state_r == WAIT);
  assign imem_addr = addr_r;
  assign halted    = halted_r;
  assign pc_out    = fifo_empty_s ? last_pc_r : head_s.pc;
  assign ins_out   = (fifo_empty_s || halted_r) ? NOP_INS : head_s.ins;

endmodule
